// File: rtl/rtp_packetizer.sv
// RTP packetizer: buffers up to PAYLOAD_WORDS payload words, then emits the
// 3-word RFC 3550 fixed header followed by the buffered payload.
module rtp_packetizer #(
   parameter int          PAYLOAD_WORDS = 360,
   parameter logic [6:0]  PT            = 7'd96,
   parameter logic [31:0] SSRC          = 32'h0000_0001,
   parameter logic [15:0] SEQ_INIT      = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   input  logic        in_sof,
   input  logic        in_eof,
   output logic        in_ready,
   input  logic [31:0] ts_in,
   output logic [31:0] rtp_data,
   output logic        rtp_valid,
   output logic        rtp_last,
   input  logic        rtp_ready
);

   localparam int CW = $clog2(PAYLOAD_WORDS + 1);
   localparam int AW = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
   localparam logic [CW-1:0] MAX_COUNT = CW'(PAYLOAD_WORDS);

   typedef enum logic [2:0] {FILL, HDR0, HDR1, HDR2, DRAIN} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] count_reg, count_next;
   logic [CW-1:0] rd_idx_reg, rd_idx_next;
   logic [15:0]   seq_reg, seq_next;
   logic [31:0]   ts_hold_reg, ts_hold_next;
   logic          marker_reg, marker_next;

   logic [31:0]   buf_mem [PAYLOAD_WORDS];
   logic [31:0]   rd_data_reg;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic [CW-1:0] count_inc;
   logic [CW-1:0] rd_idx_inc;
   logic          last_word;

   assign count_inc  = count_reg + 1'b1;
   assign rd_idx_inc = rd_idx_reg + 1'b1;
   assign last_word  = (rd_idx_inc == count_reg);
   assign wr_addr    = count_reg[AW-1:0];

   always_comb begin
      state_next   = state_reg;
      count_next   = count_reg;
      rd_idx_next  = rd_idx_reg;
      seq_next     = seq_reg;
      ts_hold_next = ts_hold_reg;
      marker_next  = marker_reg;
      in_ready     = 1'b0;
      rtp_valid    = 1'b0;
      rtp_data     = 32'h0;
      rtp_last     = 1'b0;
      wr_en        = 1'b0;
      rd_addr      = '0;

      case (state_reg)
         FILL: begin
            in_ready = !(in_sof && (count_reg != '0));
            // A new frame start closes a partially filled packet; the sof word waits for the next FILL.
            if (in_valid && in_sof && (count_reg != '0)) begin
               state_next = HDR0;
            end else if (in_valid) begin
               wr_en      = 1'b1;
               count_next = count_inc;
               if (in_sof)
                  ts_hold_next = ts_in;
               if (in_eof) begin
                  marker_next = 1'b1;
                  state_next  = HDR0;
               end else if (count_inc == MAX_COUNT) begin
                  state_next = HDR0;
               end
            end
         end
         HDR0: begin
            rtp_valid = 1'b1;
            rtp_data  = {2'b10, 1'b0, 1'b0, 4'h0, marker_reg, PT, seq_reg};
            if (rtp_ready)
               state_next = HDR1;
         end
         HDR1: begin
            rtp_valid = 1'b1;
            rtp_data  = ts_hold_reg;
            if (rtp_ready)
               state_next = HDR2;
         end
         HDR2: begin
            rtp_valid = 1'b1;
            rtp_data  = SSRC;
            if (rtp_ready)
               state_next = DRAIN;
         end
         DRAIN: begin
            rtp_valid = 1'b1;
            rtp_data  = rd_data_reg;
            rtp_last  = last_word;
            rd_addr   = rd_idx_reg[AW-1:0];
            // Read one word ahead on a handshake so the next word is ready without a bubble.
            if (rtp_ready) begin
               if (last_word) begin
                  state_next  = FILL;
                  count_next  = '0;
                  rd_idx_next = '0;
                  marker_next = 1'b0;
                  seq_next    = seq_reg + 16'd1;
                  rd_addr     = '0;
               end else begin
                  rd_idx_next = rd_idx_inc;
                  rd_addr     = rd_idx_inc[AW-1:0];
               end
            end
         end
         default: begin
            state_next = FILL;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= FILL;
         count_reg   <= '0;
         rd_idx_reg  <= '0;
         seq_reg     <= SEQ_INIT;
         ts_hold_reg <= 32'h0;
         marker_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         rd_idx_reg  <= rd_idx_next;
         seq_reg     <= seq_next;
         ts_hold_reg <= ts_hold_next;
         marker_reg  <= marker_next;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         buf_mem[wr_addr] <= in_data;
      rd_data_reg <= buf_mem[rd_addr];
   end

endmodule
